// File: rtl/integral_cache_arbiter_if.sv
// rtl/integral_cache_arbiter_if.sv - writer, loader and RAM signal bundle for the integral cache arbiter
interface integral_cache_arbiter_if #(
  parameter int WORD_SIZE   = 25,
  parameter int WORDS       = 4,
  parameter int BLOCK_WIDTH = 7,
  parameter int COL_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 15
);
  localparam int DW = WORDS * WORD_SIZE;

  logic                   frame_start;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [DW-1:0]          wr_data;
  logic                   rd_req;
  logic [COL_WIDTH-1:0]   rd_row;
  logic [BLOCK_WIDTH-1:0] rd_block;
  logic                   rd_grant;
  logic                   rd_err;
  logic                   rd_data_valid;
  logic [DW-1:0]          rd_data;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_we;
  logic [DW-1:0]          mem_wdata;
  logic [DW-1:0]          mem_rdata;
  logic [COL_WIDTH:0]     rows_done;
  logic                   frame_done;

  modport slave (
    input  frame_start, wr_valid, wr_data, rd_req, rd_row, rd_block, mem_rdata,
    output wr_ready, rd_grant, rd_err, rd_data_valid, rd_data,
           mem_addr, mem_we, mem_wdata, rows_done, frame_done
  );

  modport master (
    output frame_start, wr_valid, wr_data, rd_req, rd_row, rd_block, mem_rdata,
    input  wr_ready, rd_grant, rd_err, rd_data_valid, rd_data,
           mem_addr, mem_we, mem_wdata, rows_done, frame_done
  );
endinterface

// File: rtl/integral_cache_arbiter.sv
// rtl/integral_cache_arbiter.sv - single-port scheduler between integral writer and window loader reads
module integral_cache_arbiter #(
  parameter int WORD_SIZE    = 25,
  parameter int WORDS        = 4,
  parameter int BLOCKS       = 81,
  parameter int BLOCK_WIDTH  = 7,
  parameter int ROWS         = 241,
  parameter int COL_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 15,
  parameter int STARVE_LIMIT = 4
) (
  input logic                    clk,
  input logic                    rst,
  integral_cache_arbiter_if.slave bus
);
  localparam int DW = WORDS * WORD_SIZE;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                 state_q, state_d;
  logic [BLOCK_WIDTH-1:0] wr_block_q, wr_block_d;
  logic [ADDR_WIDTH-1:0]  wr_base_q, wr_base_d;
  logic [COL_WIDTH:0]     rows_done_q, rows_done_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic                   rd_data_valid_q, rd_data_valid_d;

  logic                   rd_in_range;
  logic                   rd_row_written;
  logic                   read_ok;
  logic                   forced;
  logic                   grant;
  logic                   accept;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [ADDR_WIDTH-1:0]  mem_addr_c;
  logic [DW-1:0]          mem_wdata_c;

  assign rd_in_range    = (int'(bus.rd_row) < ROWS) && (int'(bus.rd_block) < BLOCKS);
  assign rd_row_written = {1'b0, bus.rd_row} < rows_done_q;
  assign rd_addr        = ADDR_WIDTH'(bus.rd_row) * ADDR_WIDTH'(BLOCKS) + ADDR_WIDTH'(bus.rd_block);
  // Write address is base + block; base steps by BLOCKS on each row wrap.
  assign wr_addr        = wr_base_q + ADDR_WIDTH'(wr_block_q);

  assign read_ok = bus.rd_req && rd_in_range &&
                   ((state_q == DONE) || ((state_q == FILL) && rd_row_written));
  // Starvation only matters while the writer can actually be served.
  assign forced  = (state_q == FILL) && bus.wr_valid && (starve_q >= SW'(STARVE_LIMIT));

  always_comb begin
    state_d         = state_q;
    wr_block_d      = wr_block_q;
    wr_base_d       = wr_base_q;
    rows_done_d     = rows_done_q;
    starve_d        = starve_q;
    grant           = 1'b0;
    accept          = 1'b0;
    mem_addr_c      = '0;
    mem_wdata_c     = '0;

    if (bus.frame_start) begin
      state_d     = FILL;
      wr_block_d  = '0;
      wr_base_d   = '0;
      rows_done_d = '0;
      starve_d    = '0;
    end else begin
      if (read_ok && !forced) begin
        grant      = 1'b1;
        mem_addr_c = rd_addr;
      end else if ((state_q == FILL) && bus.wr_valid) begin
        accept      = 1'b1;
        mem_addr_c  = wr_addr;
        mem_wdata_c = bus.wr_data;
      end

      if ((state_q == FILL) && bus.wr_valid && !accept) begin
        if (starve_q < SW'(STARVE_LIMIT)) begin
          starve_d = starve_q + 1'b1;
        end
      end else begin
        starve_d = '0;
      end

      if (accept) begin
        if (int'(wr_block_q) == BLOCKS - 1) begin
          wr_block_d  = '0;
          wr_base_d   = wr_base_q + ADDR_WIDTH'(BLOCKS);
          rows_done_d = rows_done_q + 1'b1;
          if (int'(rows_done_q) == ROWS - 1) begin
            state_d = DONE;
          end
        end else begin
          wr_block_d = wr_block_q + 1'b1;
        end
      end
    end

    rd_data_valid_d = grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      wr_block_q      <= '0;
      wr_base_q       <= '0;
      rows_done_q     <= '0;
      starve_q        <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_block_q      <= wr_block_d;
      wr_base_q       <= wr_base_d;
      rows_done_q     <= rows_done_d;
      starve_q        <= starve_d;
      rd_data_valid_q <= rd_data_valid_d;
    end
  end

  assign bus.wr_ready      = accept;
  assign bus.rd_grant      = grant;
  assign bus.rd_err        = bus.rd_req && !rd_in_range;
  assign bus.rd_data_valid = rd_data_valid_q;
  assign bus.rd_data       = bus.mem_rdata;
  assign bus.mem_addr      = mem_addr_c;
  assign bus.mem_we        = accept;
  assign bus.mem_wdata     = mem_wdata_c;
  assign bus.rows_done     = rows_done_q;
  assign bus.frame_done    = (state_q == DONE);
endmodule

// File: tb/tb_integral_cache_arbiter.sv
// tb/tb_integral_cache_arbiter.sv - directed self-checking bench for integral_cache_arbiter
module tb_integral_cache_arbiter;
  localparam int DW = 100;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  integral_cache_arbiter_if bus ();

  integral_cache_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.frame_start = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_data     = '0;
    bus.rd_req      = 1'b0;
    bus.rd_row      = '0;
    bus.rd_block    = '0;
  endtask

  task automatic start_frame;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic push_beats(input int n);
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.wr_data = DW'(i);
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    bus.mem_rdata = '0;
    bus.wr_valid  = 1'b1;
    bus.rd_req    = 1'b1;
    tick();
    total++;
    if ({bus.wr_ready, bus.rd_grant, bus.mem_we, bus.rd_data_valid, bus.frame_done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {bus.wr_ready, bus.rd_grant, bus.mem_we, bus.rd_data_valid, bus.frame_done});
    end
    total++;
    if (bus.rows_done !== 9'd0 || bus.mem_addr !== 15'd0) begin
      bad++;
      $display("FAIL reset_counts rows_done=%0d mem_addr=%0d want 0/0", bus.rows_done, bus.mem_addr);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({bus.wr_ready, bus.rd_grant, bus.mem_we} !== 3'b0) begin
      bad++;
      $display("FAIL idle_blocks got=%b want=000", {bus.wr_ready, bus.rd_grant, bus.mem_we});
    end
    idle_inputs();
  endtask

  task automatic test_stream;
    bus.wr_valid = 1'b1;
    bus.frame_start = 1'b1;
    #1;
    total++;
    if (bus.mem_we !== 1'b0 || bus.wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL start_no_write we=%b ready=%b want 0/0", bus.mem_we, bus.wr_ready);
    end
    tick();
    bus.frame_start = 1'b0;
    for (int i = 0; i < 162; i++) begin
      bus.wr_data = DW'(i + 5);
      #1;
      total++;
      if (bus.mem_we !== 1'b1 || bus.wr_ready !== 1'b1 || bus.mem_addr !== 15'(i) ||
          bus.mem_wdata !== DW'(i + 5)) begin
        bad++;
        $display("FAIL stream_beat%0d we=%b ready=%b addr=%0d data=%0d want 1/1/%0d/%0d",
                 i, bus.mem_we, bus.wr_ready, bus.mem_addr, bus.mem_wdata, i, i + 5);
      end
      tick();
    end
    bus.wr_valid = 1'b0;
    #1;
    total++;
    if (bus.rows_done !== 9'd2 || bus.frame_done !== 1'b0) begin
      bad++;
      $display("FAIL stream_rows rows_done=%0d frame_done=%b want 2/0", bus.rows_done, bus.frame_done);
    end
  endtask

  task automatic test_row_read;
    logic [DW-1:0] k;
    k = {4{25'h1ABCDEF}};
    idle_inputs();
    start_frame();
    push_beats(81);
    #1;
    total++;
    if (bus.rows_done !== 9'd1) begin
      bad++;
      $display("FAIL row_read_rows1 rows_done=%0d want 1", bus.rows_done);
    end
    bus.rd_req   = 1'b1;
    bus.rd_row   = 8'd1;
    bus.rd_block = 7'd0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 81; i++) begin
      #1;
      total++;
      if (bus.rd_grant !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== 15'(81 + i)) begin
        bad++;
        $display("FAIL row_read_blocked%0d grant=%b we=%b addr=%0d want 0/1/%0d",
                 i, bus.rd_grant, bus.mem_we, bus.mem_addr, 81 + i);
      end
      tick();
    end
    bus.wr_valid = 1'b0;
    #1;
    total++;
    if (bus.rows_done !== 9'd2 || bus.rd_grant !== 1'b1 || bus.mem_we !== 1'b0 ||
        bus.mem_addr !== 15'd81 || bus.rd_data_valid !== 1'b0) begin
      bad++;
      $display("FAIL row_read_grant rows=%0d grant=%b we=%b addr=%0d dv=%b want 2/1/0/81/0",
               bus.rows_done, bus.rd_grant, bus.mem_we, bus.mem_addr, bus.rd_data_valid);
    end
    tick();
    bus.rd_req    = 1'b0;
    bus.mem_rdata = k;
    #1;
    total++;
    if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== k) begin
      bad++;
      $display("FAIL row_read_data dv=%b data=%h want 1/%h", bus.rd_data_valid, bus.rd_data, k);
    end
    tick();
    total++;
    if (bus.rd_data_valid !== 1'b0) begin
      bad++;
      $display("FAIL row_read_dv_drop dv=%b want 0", bus.rd_data_valid);
    end
  endtask

  task automatic test_starve;
    int w;
    w = 162;
    bus.rd_req   = 1'b1;
    bus.rd_row   = 8'd0;
    bus.rd_block = 7'd3;
    bus.wr_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 1; c <= 5; c++) begin
        #1;
        total++;
        if (c < 5) begin
          if (bus.rd_grant !== 1'b1 || bus.mem_we !== 1'b0 || bus.wr_ready !== 1'b0 ||
              bus.mem_addr !== 15'd3) begin
            bad++;
            $display("FAIL starve_read r%0d c%0d grant=%b we=%b ready=%b addr=%0d want 1/0/0/3",
                     r, c, bus.rd_grant, bus.mem_we, bus.wr_ready, bus.mem_addr);
          end
        end else begin
          if (bus.rd_grant !== 1'b0 || bus.mem_we !== 1'b1 || bus.wr_ready !== 1'b1 ||
              bus.mem_addr !== 15'(w)) begin
            bad++;
            $display("FAIL starve_forced r%0d grant=%b we=%b ready=%b addr=%0d want 0/1/1/%0d",
                     r, bus.rd_grant, bus.mem_we, bus.wr_ready, bus.mem_addr, w);
          end
          w++;
        end
        tick();
      end
    end
    idle_inputs();
  endtask

  task automatic test_range;
    logic [7:0] rows [3];
    logic [6:0] blks [3];
    rows = '{8'd241, 8'd0, 8'd255};
    blks = '{7'd0, 7'd81, 7'd127};
    for (int v = 0; v < 3; v++) begin
      bus.rd_req   = 1'b1;
      bus.rd_row   = rows[v];
      bus.rd_block = blks[v];
      for (int c = 0; c < 3; c++) begin
        #1;
        total++;
        if (bus.rd_err !== 1'b1 || bus.rd_grant !== 1'b0 || bus.mem_we !== 1'b0) begin
          bad++;
          $display("FAIL range_v%0d_c%0d err=%b grant=%b we=%b want 1/0/0",
                   v, c, bus.rd_err, bus.rd_grant, bus.mem_we);
        end
        tick();
      end
    end
    bus.rd_req = 1'b0;
    #1;
    total++;
    if (bus.rd_err !== 1'b0) begin
      bad++;
      $display("FAIL range_no_req err=%b want 0", bus.rd_err);
    end
    bus.rd_req   = 1'b1;
    bus.rd_row   = 8'd1;
    bus.rd_block = 7'd80;
    #1;
    total++;
    if (bus.rd_err !== 1'b0 || bus.rd_grant !== 1'b1 || bus.mem_addr !== 15'd161) begin
      bad++;
      $display("FAIL range_edge_ok err=%b grant=%b addr=%0d want 0/1/161",
               bus.rd_err, bus.rd_grant, bus.mem_addr);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_restart;
    start_frame();
    push_beats(5 * 81 + 10);
    bus.rd_req      = 1'b1;
    bus.rd_row      = 8'd2;
    bus.rd_block    = 7'd0;
    bus.wr_valid    = 1'b1;
    bus.frame_start = 1'b1;
    #1;
    total++;
    if (bus.rd_grant !== 1'b0 || bus.mem_we !== 1'b0 || bus.wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL restart_cycle grant=%b we=%b ready=%b want 0/0/0",
               bus.rd_grant, bus.mem_we, bus.wr_ready);
    end
    tick();
    bus.frame_start = 1'b0;
    #1;
    total++;
    if (bus.rows_done !== 9'd0 || bus.rd_grant !== 1'b0 || bus.mem_we !== 1'b1 ||
        bus.mem_addr !== 15'd0) begin
      bad++;
      $display("FAIL restart_first rows=%0d grant=%b we=%b addr=%0d want 0/0/1/0",
               bus.rows_done, bus.rd_grant, bus.mem_we, bus.mem_addr);
    end
    tick();
    bus.wr_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (bus.rd_grant !== 1'b0) begin
        bad++;
        $display("FAIL restart_blocked%0d grant=%b want 0", c, bus.rd_grant);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_done;
    start_frame();
    push_beats(241 * 81 - 1);
    bus.wr_valid = 1'b1;
    #1;
    total++;
    if (bus.frame_done !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd19520 ||
        bus.rows_done !== 9'd240) begin
      bad++;
      $display("FAIL done_last_write fd=%b we=%b addr=%0d rows=%0d want 0/1/19520/240",
               bus.frame_done, bus.mem_we, bus.mem_addr, bus.rows_done);
    end
    tick();
    #1;
    total++;
    if (bus.frame_done !== 1'b1 || bus.rows_done !== 9'd241 || bus.wr_ready !== 1'b0 ||
        bus.mem_we !== 1'b0) begin
      bad++;
      $display("FAIL done_state fd=%b rows=%0d ready=%b we=%b want 1/241/0/0",
               bus.frame_done, bus.rows_done, bus.wr_ready, bus.mem_we);
    end
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b1;
    bus.rd_row   = 8'd240;
    bus.rd_block = 7'd80;
    #1;
    total++;
    if (bus.rd_grant !== 1'b1 || bus.mem_addr !== 15'd19520 || bus.rd_err !== 1'b0) begin
      bad++;
      $display("FAIL done_read grant=%b addr=%0d err=%b want 1/19520/0",
               bus.rd_grant, bus.mem_addr, bus.rd_err);
    end
    tick();
    total++;
    if (bus.rd_data_valid !== 1'b1) begin
      bad++;
      $display("FAIL done_read_dv dv=%b want 1", bus.rd_data_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.rd_data_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.rows_done !== 9'd0 ||
        bus.rd_grant !== 1'b0) begin
      bad++;
      $display("FAIL midframe_reset dv=%b fd=%b rows=%0d grant=%b want 0/0/0/0",
               bus.rd_data_valid, bus.frame_done, bus.rows_done, bus.rd_grant);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_row_read();
    test_starve();
    test_range();
    test_restart();
    test_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/integral_cache_arbiter.md
Name: integral_cache_arbiter

Overview:
- Single-port scheduler in front of the blocked integral-image cache RAM.
- Sequences write addresses for the integral-image generator, which streams one block of WORDS words per beat in row-major order.
- Arbitrates random block reads from the window loader against those writes.
- Guarantees the loader never reads a row that has not been fully written.

Parameters:
- WORD_SIZE, 25, bits per integral word.
- WORDS, 4, words per block (window cache blocking).
- BLOCKS, 81, blocks per integral row.
- BLOCK_WIDTH, 7, bits to index a block within a row.
- ROWS, 241, integral rows per frame (integral column size).
- COL_WIDTH, 8, bits to index a row.
- ADDR_WIDTH, 15, RAM address bits. Address = row*BLOCKS + block.
- STARVE_LIMIT, 4, consecutive stalled writer cycles before the writer is forced a slot.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- frame_start  in  1  pulse; (re)starts a frame at row 0, block 0
- wr_valid  in  1  writer block available
- wr_ready  out  1  writer block accepted this cycle
- wr_data  in  WORDS*WORD_SIZE  writer block
- rd_req  in  1  loader read request (level, held until granted)
- rd_row  in  COL_WIDTH  requested row
- rd_block  in  BLOCK_WIDTH  requested block
- rd_grant  out  1  read issued this cycle
- rd_err  out  1  request out of range
- rd_data_valid  out  1  mem_rdata valid (rd_grant delayed by 1)
- rd_data  out  WORDS*WORD_SIZE  read block (mem_rdata passthrough)
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  WORDS*WORD_SIZE  RAM write data
- mem_rdata  in  WORDS*WORD_SIZE  RAM read data; 1-cycle latency
- rows_done  out  COL_WIDTH+1  count of fully written rows
- frame_done  out  1  all ROWS written

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE.
- States:
  - IDLE: no writes; reads rejected, rd_grant=0. frame_start -> FILL.
  - FILL: writes accepted; reads allowed for rows_done > rd_row. After the last block of row ROWS-1 is written -> DONE.
  - DONE: wr_ready=0, frame_done=1; any in-range read is eligible. frame_start -> FILL.
- Restart: frame_start in any state clears the write row/block counters, rows_done, frame_done and the starve counter, and enters FILL. No grant or write occurs in that cycle.
- Write address: kept incrementally.
  - Block counter wraps at BLOCKS-1; on wrap the row base advances by BLOCKS and rows_done increments.
  - No multiplier on the write path.
- Read address: rd_row*BLOCKS + rd_block, computed combinationally.
- Range check: rd_err=1 (combinational, while rd_req is held) when rd_row>=ROWS or rd_block>=BLOCKS. Such a request is never granted.
- Arbitration, one RAM access per cycle:
  - read_ok = rd_req & in-range & (DONE | rd_row < rows_done).
  - Writer forced when the starve counter has reached STARVE_LIMIT. Starve counter: increments while wr_valid and the writer is not accepted; clears on acceptance or when wr_valid is low.
  - If read_ok and not forced: rd_grant=1, mem_we=0, mem_addr = read address.
  - Else if FILL and wr_valid: wr_ready=1, mem_we=1, mem_addr = write address, mem_wdata = wr_data.
  - Otherwise idle: mem_we=0.
- Combinational outputs: wr_ready, rd_grant, mem_we, mem_addr and mem_wdata are combinational from the current state and inputs. Handshakes complete in the same cycle.
- Read data: rd_data_valid is a registered copy of rd_grant; rd_data = mem_rdata. A read of a row is never reordered ahead of that row's final write.
- Row boundary: the write completing row r and a read of row r in the same cycle are not both possible, because rows_done updates only after the write. The read is granted the following cycle at the earliest.
- Reset mid-frame: immediate return to IDLE. An in-flight rd_data_valid is cleared.

Test Plan:
- Reset, frame_start, writer streams 2*BLOCKS beats with no reads -> mem_addr 0..161 with mem_we=1 each beat; rows_done=2 after beat 162.
- rows_done=1, rd_req row 1 block 0 -> no grant; after row 1 completes, grant the next cycle with mem_addr=81; rd_data_valid one cycle later.
- Continuous reads of row 0 plus continuous wr_valid -> writer stalled 4 cycles, then accepted in cycle 5; pattern repeats.
- rd_req row 241, or row 0 block 81 -> rd_err=1 and rd_grant=0 indefinitely.
- Complete all 241 rows -> frame_done=1, wr_ready=0; read row 240 block 80 -> mem_addr=19520.
- frame_start mid-row 5 with rd_req row 2 the same cycle -> no grant that cycle; rows_done=0 and the next write goes to address 0; the row 2 read stays blocked.
